// File: rtl/mem_bus_pkg.sv
// Shared widths, master indices and read latency for the memory bus arbiter.
package mem_bus_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int WEN_W_DEF  = DATA_W_DEF / 8;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  // Downstream memory returns read data this many cycles after the address.
  localparam int RD_LAT = 1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; force1 lets master 1 win a tie regardless of history.
// Latency: combinational, 0 cycles.
// Backpressure: a losing requester simply sees no grant and keeps its request up.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       force1,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (force1 || last_gnt == MST_CPU) gnt = 2'b10;
      else                               gnt = 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory controller data port between CPU (M0) and DMA (M1) with optional bounded M1 lock.
// Latency: grant is combinational; read data returns with rvalid one cycle after the grant.
// Backpressure: an ungranted master holds its request; no grant means s_wen is forced to zero.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEN_W    = WEN_W_DEF,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [WEN_W-1:0]  m0_wen,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [WEN_W-1:0]  m1_wen,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [WEN_W-1:0]  s_wen,
  input  logic [DATA_W-1:0] s_rdata
);

  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

  logic           last_gnt;
  logic           rd_pend;
  logic           rd_owner;
  logic [LCW-1:0] lock_cnt;
  logic           locked;
  logic [1:0]     arb_gnt;
  logic [1:0]     gnt;

  assign locked = m1_lock && (last_gnt == MST_DMA) && (lock_cnt < LOCK_MAX);

  rr_arb2 u_rr_arb2 (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt),
    .force1   (locked),
    .gnt      (arb_gnt)
  );

  // No grant may escape while reset is held, even if requests are already up.
  assign gnt    = arb_gnt & {2{rst_n}};
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    s_addr  = m0_addr;
    s_wdata = m0_wdata;
    s_wen   = '0;
    if (gnt[1]) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wen   = m1_wen;
    end else if (gnt[0]) begin
      s_wen   = m0_wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= MST_DMA;
      rd_pend  <= 1'b0;
      rd_owner <= MST_CPU;
      lock_cnt <= '0;
    end else begin
      if (gnt != 2'b00) begin
        last_gnt <= gnt[1];
        rd_owner <= gnt[1];
        rd_pend  <= (s_wen == '0);
      end else begin
        rd_pend  <= 1'b0;
      end
      // Count only M1 grants that actually starve a waiting M0.
      if (gnt[0] || !m1_lock)
        lock_cnt <= '0;
      else if (gnt[1] && m0_req && lock_cnt != LOCK_MAX)
        lock_cnt <= lock_cnt + 1'b1;
    end
  end

  assign m0_rvalid = rd_pend && (rd_owner == MST_CPU);
  assign m1_rvalid = rd_pend && (rd_owner == MST_DMA);
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core-side data port of the memory controller between two masters: M0 (CPU load/store unit) and M1 (DMA / debug loader).
- Per-cycle round-robin arbitration. M1 may optionally lock the bus for bursts, bounded by a cycle limit.
- Sits between the requesters and the memory controller's data port (in_datamem_addr / wdata / wen / rdata).
- Downstream memory is synchronous: read data returns exactly one cycle after the address is presented.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- WEN_W, 4, byte write-enable width (DATA_W/8).
- MAX_LOCK, 8, maximum consecutive M1 grants under lock while M0 is requesting (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  M0 access request; held until granted.
- m0_addr  in  ADDR_W  M0 byte address.
- m0_wdata  in  DATA_W  M0 write data.
- m0_wen  in  WEN_W  M0 byte enables; 0 means read.
- m0_gnt  out  1  M0 access accepted this cycle (combinational).
- m0_rvalid  out  1  M0 read data valid (registered).
- m0_rdata  out  DATA_W  M0 read data.
- m1_req, m1_addr, m1_wdata, m1_wen, m1_gnt, m1_rvalid, m1_rdata: same as the M0 equivalents, for M1.
- m1_lock  in  1  M1 requests to keep ownership on its next request.
- s_addr  out  ADDR_W  address to the memory controller data port.
- s_wdata  out  DATA_W  write data to the memory controller.
- s_wen  out  WEN_W  byte enables to the memory controller; gated to 0 when no grant.
- s_rdata  in  DATA_W  read data from the memory controller, valid one cycle after address.

Behaviour:
- Reset (async assert, sync release):
  - last_gnt=1, so M0 wins the first tie.
  - rd_pend=0, rd_owner=0, lock_cnt=0.
  - Outputs: m0_rvalid=0, m1_rvalid=0, gnt outputs 0, s_wen=0.
- Arbitration (combinational, every cycle):
  - Only one requester: it is granted.
  - Both requesting: the master not equal to last_gnt is granted.
  - Exception: M1 wins if locked=1, where locked = m1_lock && last_gnt==1 && lock_cnt<MAX_LOCK.
  - Neither requesting: no grant.
- At most one gnt is high per cycle (one-hot or zero).
- Datapath mux:
  - s_addr/s_wdata/s_wen come from the granted master.
  - With no grant: s_wen=0, and s_addr/s_wdata hold the M0 values (don't-care).
- Registered state on each clock edge with a grant:
  - last_gnt <= granted index.
  - rd_pend <= (granted wen==0); rd_owner <= granted index.
- With no grant: rd_pend <= 0, last_gnt unchanged.
- Read return: in the cycle after a granted read, rd_pend=1.
  - mX_rvalid = rd_pend && rd_owner==X.
  - mX_rdata = s_rdata for both masters; only rvalid qualifies it.
- Read latency is 1 cycle. Back-to-back reads (from the same or alternating masters) sustain 1 access/cycle.
- Writes complete on gnt and produce no rvalid.
- lock_cnt:
  - Increments when M1 is granted while M0 is requesting and the lock is in use.
  - Resets to 0 on any M0 grant, or when m1_lock=0.
  - Saturates at MAX_LOCK. At MAX_LOCK, M0 gets the next grant if requesting.
- Lock with no M0 request does not increment lock_cnt; M1 streams unbounded.
- A master dropping req without a grant is legal: no side effects.
- Reset mid-read: a pending rvalid is discarded and never asserted after reset release.
- A grant with wen!=0 and a read from the other master cannot coincide (single port).

Decomposition:
- Package mem_bus_pkg: ADDR_W/DATA_W/WEN_W defaults, master index constants MST_CPU=0 and MST_DMA=1, and a localparam for read latency (1).
- Sub-module rr_arb2: 2-way round-robin grant logic.
  - Inputs: req[1:0], last_gnt, force1.
  - Output: one-hot gnt[1:0].
  - Purely combinational.
- The top module holds the lock counter, pending-read tracking and datapath mux.

Test Plan:
- Reset mid-read: M0 read granted, then rst_n pulsed low in the next cycle. Required: m0_rvalid stays 0; after release, M0 wins the first tie.
- Single master: M0 reads 0x0001_0000 (s_rdata=0xDEADBEEF). Required: m0_gnt in cycle 0; m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 1; m1_rvalid=0.
- Contention, both reading continuously for 6 cycles after reset. Required:
  - Grants alternate M0,M1,M0,M1,M0,M1.
  - Each rvalid arrives one cycle after the corresponding grant, to the correct owner.
- Mixed: M1 write (wen=4'b0011) and M0 read requested in the same cycle. Required:
  - One is granted, then the other the next cycle.
  - s_wen=4'b0011 only in the M1 grant cycle.
  - No rvalid follows the write.
- Lock, MAX_LOCK=8: M1 with m1_lock=1 and M0 requesting continuously. Required:
  - M1 is granted 8 consecutive cycles, then M0 is granted.
  - Repeat with M0 idle: M1 is granted for 20+ cycles with no yield.
- Idle: no requests for 5 cycles. Required: s_wen=0, no gnt, no rvalid, last_gnt unchanged.
